// File: rtl/vram_pkg.sv
// Shared VRAM constants, write-queue entry layout and the {y,x} address packing
// used by both the writer and the display reader.
package vram_pkg;

    localparam int VRAM_ADDR_W      = 19;
    localparam int VRAM_DATA_W      = 36;
    localparam int PIX_W            = 30;
    localparam int X_W              = 10;
    localparam int Y_W              = 9;
    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef struct packed {
        logic                   last;
        logic [VRAM_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]       pix;
    } wr_entry_t;

    function automatic logic [VRAM_ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                         input logic [X_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; dout is the head entry whenever empty is low.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != CNT_FULL);
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/vram_writer.sv
// Tags incoming pixels with raster coordinates, queues them, and issues ZBT writes
// whose data follows the write enable by two cycles (late-write pipeline).
module vram_writer
    import vram_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [PIX_W-1:0]       pix_data,
    output logic                   pix_ready,
    input  logic                   wr_allow,
    output logic [VRAM_ADDR_W-1:0] vram_addr,
    output logic                   vram_we,
    output logic [VRAM_DATA_W-1:0] vram_write_data,
    output logic                   frame_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);
    localparam logic [X_W-1:0]   X_LAST  = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_ACTIVE - 1);

    logic [X_W-1:0]         x_q, x_d, cur_x;
    logic [Y_W-1:0]         y_q, y_d, cur_y;
    logic                   run_q, run_d;
    logic                   vram_we_q, vram_we_d;
    logic [VRAM_ADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic                   frame_done_q, frame_done_d;
    logic [VRAM_DATA_W-1:0] wdata_s1_q, wdata_s1_d;
    logic [VRAM_DATA_W-1:0] wdata_s2_q, wdata_s2_d;
    logic [VRAM_DATA_W-1:0] wdata_q, wdata_d;

    logic                   accept, pop, at_eol, at_eof;
    wr_entry_t              push_entry, head_entry;
    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    // run_q keeps pix_ready low until the first edge that sees reset released.
    assign pix_ready = reset && run_q && (fifo_count < CNT_MAX);

    always_comb begin
        accept     = pix_valid && pix_ready && !fifo_full;
        pop        = wr_allow && !fifo_empty;
        cur_x      = frame_start ? '0 : x_q;
        cur_y      = frame_start ? '0 : y_q;
        at_eol     = (cur_x == X_LAST);
        at_eof     = at_eol && (cur_y == Y_LAST);
        push_entry = '{last: at_eof, addr: pack_addr(cur_y, cur_x), pix: pix_data};

        x_d = cur_x;
        y_d = cur_y;
        if (accept) begin
            if (at_eol) begin
                x_d = '0;
                y_d = at_eof ? '0 : cur_y + 1'b1;
            end else begin
                x_d = cur_x + 1'b1;
            end
        end

        run_d        = 1'b1;
        vram_we_d    = pop;
        vram_addr_d  = pop ? head_entry.addr : vram_addr_q;
        frame_done_d = pop && head_entry.last;
        wdata_s1_d   = pop ? {6'd0, head_entry.pix} : '0;
        wdata_s2_d   = wdata_s1_q;
        wdata_d      = wdata_s2_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q          <= '0;
            y_q          <= '0;
            run_q        <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            frame_done_q <= 1'b0;
            wdata_s1_q   <= '0;
            wdata_s2_q   <= '0;
            wdata_q      <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            run_q        <= run_d;
            vram_we_q    <= vram_we_d;
            vram_addr_q  <= vram_addr_d;
            frame_done_q <= frame_done_d;
            wdata_s1_q   <= wdata_s1_d;
            wdata_s2_q   <= wdata_s2_d;
            wdata_q      <= wdata_d;
        end
    end

    sync_fifo #(
        .WIDTH($bits(wr_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign vram_we         = vram_we_q;
    assign vram_addr       = vram_addr_q;
    assign vram_write_data = wdata_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer; a negedge monitor logs every write and every
// non-zero data beat so tests can check addresses, ordering and the 2-cycle data lag.
module tb_vram_writer;
    import vram_pkg::*;

    // Frame height is reduced so a complete frame wrap fits in a short run.
    localparam int TB_H     = 640;
    localparam int TB_V     = 8;
    localparam int TB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic        wr_allow = 1'b0;
    logic [29:0] pix_data = '0;
    logic        pix_ready, vram_we, frame_done;
    logic [18:0] vram_addr;
    logic [35:0] vram_write_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_count = 0;
    int done_count = 0;
    int w_base = 0;
    int d_base = 0;
    int done_base = 0;

    logic [18:0] wq_addr[$];
    int          wq_cyc[$];
    bit          wq_done[$];
    logic [35:0] dq_data[$];
    int          dq_cyc[$];

    logic [29:0] t2_pix[3];
    int          t6_addr[7];

    vram_writer #(
        .H_ACTIVE(TB_H),
        .V_ACTIVE(TB_V),
        .FIFO_DEPTH(TB_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .wr_allow        (wr_allow),
        .vram_addr       (vram_addr),
        .vram_we         (vram_we),
        .vram_write_data (vram_write_data),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vram_we) begin
            wq_addr.push_back(vram_addr);
            wq_cyc.push_back(cyc);
            wq_done.push_back(frame_done);
        end
        if (frame_done) done_count++;
        if (vram_write_data != '0) begin
            dq_data.push_back(vram_write_data);
            dq_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [29:0] data, input logic fs, input logic allow);
        pix_valid   = valid;
        pix_data    = data;
        frame_start = fs;
        wr_allow    = allow;
        #3;
        if (valid && pix_ready) acc_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic markLog();
        w_base    = wq_addr.size();
        d_base    = dq_data.size();
        done_base = done_count;
    endtask

    function automatic int nWrites();
        return wq_addr.size() - w_base;
    endfunction

    function automatic int nData();
        return dq_data.size() - d_base;
    endfunction

    function automatic logic [18:0] wAddr(input int i);
        if (w_base + i < wq_addr.size()) return wq_addr[w_base + i];
        return '1;
    endfunction

    function automatic int wCyc(input int i);
        if (w_base + i < wq_cyc.size()) return wq_cyc[w_base + i];
        return -100;
    endfunction

    function automatic bit wDone(input int i);
        if (w_base + i < wq_done.size()) return wq_done[w_base + i];
        return 1'b0;
    endfunction

    function automatic logic [35:0] dData(input int i);
        if (d_base + i < dq_data.size()) return dq_data[d_base + i];
        return '1;
    endfunction

    function automatic int dCyc(input int i);
        if (d_base + i < dq_cyc.size()) return dq_cyc[d_base + i];
        return -100;
    endfunction

    initial begin
        int acc0;
        t2_pix  = '{30'h3FF00000, 30'h000FFC00, 30'h000003FF};
        t6_addr = '{1, 2, 3, 4, 5, 0, 1};

        // Reset held with traffic offered: nothing accepted, all outputs quiet.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 30'h1, 1'b0, 1'b1);
        checkOutput("rst_ready",  64'(pix_ready), 64'd0);
        checkOutput("rst_we",     64'(vram_we), 64'd0);
        checkOutput("rst_addr",   64'(vram_addr), 64'd0);
        checkOutput("rst_wdata",  64'(vram_write_data), 64'd0);
        checkOutput("rst_done",   64'(frame_done), 64'd0);
        checkOutput("rst_accept", 64'(acc_count), 64'd0);
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("release_ready", 64'(pix_ready), 64'd1);

        // Three pixels after frame_start: back-to-back writes at 0,1,2, data two cycles later.
        markLog();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, t2_pix[i], 1'b0, 1'b1);
        idle(6);
        checkOutput("t2_nwr", 64'(nWrites()), 64'd3);
        checkOutput("t2_ndata", 64'(nData()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t2_addr%0d", i), 64'(wAddr(i)), 64'(i));
            checkOutput($sformatf("t2_data%0d", i), 64'(dData(i)), 64'({6'd0, t2_pix[i]}));
            checkOutput($sformatf("t2_lag%0d", i), 64'(dCyc(i) - wCyc(i)), 64'd2);
        end
        checkOutput("t2_b2b_1", 64'(wCyc(1) - wCyc(0)), 64'd1);
        checkOutput("t2_b2b_2", 64'(wCyc(2) - wCyc(1)), 64'd1);

        // Backpressure: with writes blocked, exactly four pixels are taken.
        markLog();
        acc0 = acc_count;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 30'h100 + 30'(i), 1'b0, 1'b0);
        checkOutput("t3_accepts", 64'(acc_count - acc0), 64'd4);
        checkOutput("t3_ready_full", 64'(pix_ready), 64'd0);
        checkOutput("t3_no_we", 64'(nWrites()), 64'd0);
        pix_valid = 1'b0;
        wr_allow  = 1'b1;
        #1;
        checkOutput("t3_ready_vs_allow", 64'(pix_ready), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("t3_ready_back", 64'(pix_ready), 64'd1);
        checkOutput("t3_first_we", 64'(vram_we), 64'd1);
        idle(6);
        checkOutput("t3_nwr", 64'(nWrites()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_addr%0d", i), 64'(wAddr(i)), 64'(3 + i));
            checkOutput($sformatf("t3_data%0d", i), 64'(dData(i)), 64'(36'h100 + 36'(i)));
        end
        checkOutput("t3_we_idle", 64'(vram_we), 64'd0);
        checkOutput("t3_addr_hold", 64'(vram_addr), 64'd6);

        // Line wrap: 640th pixel ends row 0, 641st starts row 1.
        doReset();
        markLog();
        for (int i = 0; i < TB_H + 1; i++) applyStimulus(1'b1, 30'(i + 1), 1'b0, 1'b1);
        idle(5);
        checkOutput("t4_nwr", 64'(nWrites()), 64'(TB_H + 1));
        checkOutput("t4_addr_first", 64'(wAddr(0)), 64'h0);
        checkOutput("t4_addr_eol", 64'(wAddr(TB_H - 1)), 64'h0027F);
        checkOutput("t4_addr_nextline", 64'(wAddr(TB_H)), 64'h00400);

        // Frame wrap: last pixel at (639,7) raises frame_done once; next goes to 0.
        doReset();
        markLog();
        acc0 = acc_count;
        for (int i = 0; i < TB_H * TB_V + 1; i++) applyStimulus(1'b1, 30'(i + 1), 1'b0, 1'b1);
        idle(5);
        checkOutput("t5_accepts", 64'(acc_count - acc0), 64'(TB_H * TB_V + 1));
        checkOutput("t5_nwr", 64'(nWrites()), 64'(TB_H * TB_V + 1));
        checkOutput("t5_last_addr", 64'(wAddr(TB_H * TB_V - 1)), 64'h01E7F);
        checkOutput("t5_last_done", 64'(wDone(TB_H * TB_V - 1)), 64'd1);
        checkOutput("t5_done_pulses", 64'(done_count - done_base), 64'd1);
        checkOutput("t5_wrap_addr", 64'(wAddr(TB_H * TB_V)), 64'h0);
        checkOutput("t5_wrap_done", 64'(wDone(TB_H * TB_V)), 64'd0);

        // frame_start on the 6th pixel re-homes it; earlier pixels keep their addresses.
        markLog();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 30'h200 + 30'(i), (i == 5), 1'b1);
        idle(5);
        checkOutput("t6_nwr", 64'(nWrites()), 64'd7);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("t6_addr%0d", i), 64'(wAddr(i)), 64'(t6_addr[i]));
        end

        // Reset with entries queued and one write in flight discards everything.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 30'h300 + 30'(i), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        markLog();
        checkOutput("t7_we", 64'(vram_we), 64'd0);
        checkOutput("t7_addr", 64'(vram_addr), 64'd0);
        checkOutput("t7_wdata", 64'(vram_write_data), 64'd0);
        checkOutput("t7_done", 64'(frame_done), 64'd0);
        checkOutput("t7_ready", 64'(pix_ready), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("t7_ready_back", 64'(pix_ready), 64'd1);
        idle(6);
        checkOutput("t7_no_writes", 64'(nWrites()), 64'd0);
        checkOutput("t7_no_data", 64'(nData()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
